dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-port data-memory responder: valid/ready request and
//            response handshakes, LATENCY wait states, byte-lane stores.
//            Optional macro DMEM_RESP_ERR_EN enables misaligned and
//            out-of-range access errors.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [3:0]            req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int       c_words = 1 << DEPTH_LOG2;
  localparam bit [3:0] c_lat   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [3:0]              r_be;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_mem [c_words];

  logic                    w_access;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic                    w_we;
  logic [3:0]              w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic                    w_err;

  // A zero-latency access happens in the acceptance cycle, before the latch.
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_be    = (r_state == S_IDLE) ? req_be    : r_be;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_idx   = w_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_RESP_ERR_EN
  assign w_err = (|w_addr[1:0]) | (|(w_addr >> (DEPTH_LOG2 + 2)));
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{w_addr[1:0], w_addr[ADDR_WIDTH-1:DEPTH_LOG2+2]};
  assign w_err         = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_access    = 1'b1;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_nxt   = c_lat;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_access    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_mem_we = w_access && w_we && !w_err && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_be    <= req_be;
        r_wdata <= req_wdata;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_we || w_err) ? '0 : r_mem[w_idx];
      end
    end
  end

  // Memory array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = (r_state == S_RESP) && !rst;
  assign resp_rdata = rst ? '0 : r_rdata;
  assign resp_err   = r_err && !rst;

endmodule
`default_nettype wire
